// File: rtl/register_bank_mp.sv
// register_bank_mp: multi-port MIPS general-purpose register file.
//   - N_READ_PORTS combinational read ports and two prioritised synchronous
//     write ports. Port 1 wins when both ports hit the same address.
//   - Register 0 reads as zero and ignores writes.
//   - A debug dump engine streams every register in index order over
//     valid/ready.
// Optional feature macro: REGISTER_BANK_BYPASS_EN.
//   When it is defined, reads see a committing write in the same cycle.
//   This also applies to the dump LOAD capture.

// One read port: an array lookup, optional write bypass, and a zero override.
module register_bank_mp_rd_port #(
   parameter int NB_DATA     = 32,
   parameter int N_REGISTERS = 32,
   parameter int NB_REGISTER = 5
) (
   input  logic [N_REGISTERS-1:0][NB_DATA-1:0] i_regs,
   input  logic [NB_REGISTER-1:0]              i_sel,
`ifdef REGISTER_BANK_BYPASS_EN
   input  logic [1:0]                          i_wr_commit,
   input  logic [1:0][NB_REGISTER-1:0]         i_wr_sel,
   input  logic [1:0][NB_DATA-1:0]             i_wr_data,
`endif
   output logic [NB_DATA-1:0]                  o_data
);

   // Array read. The bypass is checked port 0 first so port 1 overrides it.
   // Select 0 is forced to zero last.
   always_comb begin
      o_data = i_regs[i_sel];
`ifdef REGISTER_BANK_BYPASS_EN
      if (i_wr_commit[0] && (i_wr_sel[0] == i_sel)) o_data = i_wr_data[0];
      if (i_wr_commit[1] && (i_wr_sel[1] == i_sel)) o_data = i_wr_data[1];
`endif
      if (i_sel == '0) o_data = '0;
   end

endmodule

module register_bank_mp #(
   parameter int NB_DATA      = 32,
   parameter int N_REGISTERS  = 32,
   parameter int NB_REGISTER  = 5,
   parameter int N_READ_PORTS = 2
) (
   input  logic                              i_clock,
   input  logic                              i_reset,
   input  logic                              i_valid,
   input  logic [N_READ_PORTS*NB_REGISTER-1:0] i_read_sel,
   output logic [N_READ_PORTS*NB_DATA-1:0]   o_read_data,
   input  logic                              i_wr0_enable,
   input  logic [NB_REGISTER-1:0]            i_wr0_sel,
   input  logic [NB_DATA-1:0]                i_wr0_data,
   input  logic                              i_wr1_enable,
   input  logic [NB_REGISTER-1:0]            i_wr1_sel,
   input  logic [NB_DATA-1:0]                i_wr1_data,
   input  logic                              i_dump_start,
   input  logic                              i_dump_ready,
   output logic                              o_dump_valid,
   output logic [NB_DATA-1:0]                o_dump_data,
   output logic [NB_REGISTER-1:0]            o_dump_addr,
   output logic                              o_dump_busy,
   output logic                              o_dump_done
);

   localparam logic [NB_REGISTER-1:0] LAST_IDX = NB_REGISTER'(N_REGISTERS - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SEND, ST_DONE} dump_state_t;

   logic [N_REGISTERS-1:0][NB_DATA-1:0] regs;

   // The write ports are collected into index-1 packed arrays.
   // Index 1 is the higher-priority port.
   logic [1:0]                  wr_commit;
   logic [1:0][NB_REGISTER-1:0] wr_sel;
   logic [1:0][NB_DATA-1:0]     wr_data;

   dump_state_t            state, state_nxt;
   logic [NB_REGISTER-1:0] dump_idx, dump_idx_nxt;
   logic [NB_DATA-1:0]     dump_data_nxt;
   logic [NB_REGISTER-1:0] dump_addr_nxt;
   logic [NB_DATA-1:0]     dump_word;

   assign wr_sel    = {i_wr1_sel, i_wr0_sel};
   assign wr_data   = {i_wr1_data, i_wr0_data};
   // A write commits only when the pipeline advances and the target is nonzero.
   assign wr_commit = {i_valid && i_wr1_enable && (i_wr1_sel != '0),
                       i_valid && i_wr0_enable && (i_wr0_sel != '0)};

   // Register array. Port 1 is applied last so it wins on an address collision.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         regs <= '0;
      end else begin
         for (int w = 0; w < 2; w++)
            if (wr_commit[w]) regs[wr_sel[w]] <= wr_data[w];
      end
   end

   for (genvar k = 0; k < N_READ_PORTS; k++) begin : g_rd
      register_bank_mp_rd_port #(
         .NB_DATA(NB_DATA), .N_REGISTERS(N_REGISTERS), .NB_REGISTER(NB_REGISTER)
      ) u_rd (
         .i_regs      (regs),
         .i_sel       (i_read_sel[k*NB_REGISTER +: NB_REGISTER]),
`ifdef REGISTER_BANK_BYPASS_EN
         .i_wr_commit (wr_commit),
         .i_wr_sel    (wr_sel),
         .i_wr_data   (wr_data),
`endif
         .o_data      (o_read_data[k*NB_DATA +: NB_DATA])
      );
   end

   // The dump engine has its own read port, so its capture bypasses the same
   // way the datapath reads do.
   register_bank_mp_rd_port #(
      .NB_DATA(NB_DATA), .N_REGISTERS(N_REGISTERS), .NB_REGISTER(NB_REGISTER)
   ) u_dump_rd (
      .i_regs      (regs),
      .i_sel       (dump_idx),
`ifdef REGISTER_BANK_BYPASS_EN
      .i_wr_commit (wr_commit),
      .i_wr_sel    (wr_sel),
      .i_wr_data   (wr_data),
`endif
      .o_data      (dump_word)
   );

   // Dump FSM state, index and captured word/address.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state       <= ST_IDLE;
         dump_idx    <= '0;
         o_dump_data <= '0;
         o_dump_addr <= '0;
      end else begin
         state       <= state_nxt;
         dump_idx    <= dump_idx_nxt;
         o_dump_data <= dump_data_nxt;
         o_dump_addr <= dump_addr_nxt;
      end
   end

   // Dump FSM next state. The word is captured in LOAD and held through SEND.
   always_comb begin
      state_nxt     = state;
      dump_idx_nxt  = dump_idx;
      dump_data_nxt = o_dump_data;
      dump_addr_nxt = o_dump_addr;
      case (state)
         ST_IDLE: begin
            if (i_dump_start) begin
               state_nxt    = ST_LOAD;
               dump_idx_nxt = '0;
            end
         end
         ST_LOAD: begin
            dump_data_nxt = dump_word;
            dump_addr_nxt = dump_idx;
            state_nxt     = ST_SEND;
         end
         ST_SEND: begin
            if (i_dump_ready) begin
               if (dump_idx == LAST_IDX) begin
                  state_nxt = ST_DONE;
               end else begin
                  dump_idx_nxt = dump_idx + 1'b1;
                  state_nxt    = ST_LOAD;
               end
            end
         end
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Status outputs decode directly from the state, so reset forces them low.
   always_comb begin
      o_dump_valid = (state == ST_SEND);
      o_dump_busy  = (state != ST_IDLE);
      o_dump_done  = (state == ST_DONE);
   end

endmodule
